// File: rtl/l2_cache_pkg.sv
// Shared types and size helpers for the L2 N-way tag/data array.
package l2_cache_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'b00,
    WRITE  = 2'b01,
    FILL   = 2'b10
  } l2_op_t;

  typedef enum logic [1:0] {
    FlushIdle,
    FlushScan,
    FlushWb
  } flush_state_t;

  localparam int unsigned L2_S_INDEX    = 3;
  localparam int unsigned L2_NUM_WAYS   = 4;
  localparam int unsigned L2_TAG_WIDTH  = 24;
  localparam int unsigned L2_LINE_BYTES = 32;
  localparam int unsigned L2_LINE_BITS  = 8 * L2_LINE_BYTES;
  localparam int unsigned L2_WAY_W      = $clog2(L2_NUM_WAYS);

  function automatic int unsigned line_bits(int unsigned bytes);
    return 8 * bytes;
  endfunction

  function automatic int unsigned way_w(int unsigned ways);
    return (ways < 2) ? 1 : $clog2(ways);
  endfunction

endpackage

// File: rtl/l2_nway_array_if.sv
// Request/response bus between the L2 control FSM (master) and the tag/data array (slave).
interface l2_nway_array_if
  import l2_cache_pkg::*;
#(
  parameter int unsigned S_INDEX    = L2_S_INDEX,
  parameter int unsigned NUM_WAYS   = L2_NUM_WAYS,
  parameter int unsigned TAG_WIDTH  = L2_TAG_WIDTH,
  parameter int unsigned LINE_BYTES = L2_LINE_BYTES
) ();

  localparam int unsigned LINE_BITS = line_bits(LINE_BYTES);
  localparam int unsigned WAY_W     = way_w(NUM_WAYS);

  logic                  req_valid;
  logic                  req_ready;
  l2_op_t                req_op;
  logic [S_INDEX-1:0]    req_index;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [LINE_BITS-1:0]  req_wdata;
  logic [LINE_BYTES-1:0] req_wmask;
  logic                  req_fill_dirty;

  logic                  rsp_valid;
  logic                  rsp_hit;
  logic [WAY_W-1:0]      rsp_way;
  logic [LINE_BITS-1:0]  rsp_rdata;
  logic                  rsp_evict;
  logic [TAG_WIDTH-1:0]  rsp_evict_tag;
  logic [LINE_BITS-1:0]  rsp_evict_data;

  modport master (
    output req_valid, req_op, req_index, req_tag, req_wdata, req_wmask, req_fill_dirty,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_rdata, rsp_evict, rsp_evict_tag,
           rsp_evict_data
  );

  modport slave (
    input  req_valid, req_op, req_index, req_tag, req_wdata, req_wmask, req_fill_dirty,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_rdata, rsp_evict, rsp_evict_tag,
           rsp_evict_data
  );

endinterface

// File: rtl/l2_plru.sv
// Combinational tree-PLRU: victim walk and access update for one set's node bits.
module l2_plru #(
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits_i,
  input  logic [WAY_W-1:0]    access_way_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic [NUM_WAYS-2:0] bits_o
);

  // Nodes are heap-ordered: children of n are 2n+1 (lower ways) and 2n+2 (upper ways).
  always_comb begin : victim_walk
    logic [WAY_W-1:0] node;
    node     = '0;
    victim_o = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_o = (victim_o << 1) | WAY_W'(bits_i[node]);
      node     = (node << 1) + WAY_W'(1) + WAY_W'(bits_i[node]);
    end
  end

  always_comb begin : update_walk
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] path;
    logic             dir;
    bits_o = bits_i;
    node   = '0;
    path   = access_way_i;
    for (int l = 0; l < WAY_W; l++) begin
      dir          = path[WAY_W-1];
      path         = path << 1;
      bits_o[node] = ~dir;
      node         = (node << 1) + WAY_W'(1) + WAY_W'(dir);
    end
  end

endmodule

// File: rtl/l2_nway_array.sv
// N-way set-associative L2 tag/data store: hit detection, PLRU fills with dirty eviction,
// byte-masked write hits and a flush engine draining dirty lines through a write-back port.
module l2_nway_array
  import l2_cache_pkg::*;
#(
  parameter int unsigned S_INDEX    = L2_S_INDEX,
  parameter int unsigned NUM_WAYS   = L2_NUM_WAYS,
  parameter int unsigned TAG_WIDTH  = L2_TAG_WIDTH,
  parameter int unsigned LINE_BYTES = L2_LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  l2_nway_array_if.slave          bus,
  input  logic                    flush_start,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [S_INDEX-1:0]      wb_index,
  output logic [TAG_WIDTH-1:0]    wb_tag,
  output logic [8*LINE_BYTES-1:0] wb_data
);

  localparam int unsigned SETS      = 2 ** S_INDEX;
  localparam int unsigned LINE_BITS = line_bits(LINE_BYTES);
  localparam int unsigned WAY_W     = way_w(NUM_WAYS);

  typedef logic [S_INDEX-1:0]   idx_t;
  typedef logic [WAY_W-1:0]     way_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [LINE_BITS-1:0] line_t;

  logic [SETS-1:0][NUM_WAYS-1:0]        valid_q, valid_d;
  logic [SETS-1:0][NUM_WAYS-1:0]        dirty_q, dirty_d;
  tag_t [SETS-1:0][NUM_WAYS-1:0]        tag_q, tag_d;
  line_t [SETS-1:0][NUM_WAYS-1:0]       data_q, data_d;
  logic [SETS-1:0][NUM_WAYS-2:0]        plru_q, plru_d;

  logic  rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_evict_q, rsp_evict_d;
  way_t  rsp_way_q, rsp_way_d;
  line_t rsp_rdata_q, rsp_rdata_d, rsp_evict_data_q, rsp_evict_data_d;
  tag_t  rsp_evict_tag_q, rsp_evict_tag_d;

  flush_state_t state_q, state_d;
  idx_t  fset_q, fset_d, wb_index_q, wb_index_d;
  way_t  fway_q, fway_d;
  logic  wb_valid_q, wb_valid_d, flush_busy_q, flush_busy_d, flush_done_q, flush_done_d;
  tag_t  wb_tag_q, wb_tag_d;
  line_t wb_data_q, wb_data_d;
  logic  wb_clear;

  idx_t  idx;
  logic  req_fire, hit, inv_found;
  way_t  hit_way, inv_way, plru_victim, fill_way, access_way;
  line_t hit_line, merged;
  logic [NUM_WAYS-2:0] plru_next;

  assign idx           = bus.req_index;
  assign bus.req_ready = (state_q == FlushIdle) && !flush_start;
  assign req_fire      = bus.req_valid && bus.req_ready;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == bus.req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Walk downwards so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    hit_line = data_q[idx][hit_way];
    for (int b = 0; b < LINE_BYTES; b++) begin
      merged[8*b +: 8] = bus.req_wmask[b] ? bus.req_wdata[8*b +: 8] : hit_line[8*b +: 8];
    end
    fill_way   = hit ? hit_way : (inv_found ? inv_way : plru_victim);
    access_way = (bus.req_op == FILL) ? fill_way : hit_way;
  end

  l2_plru #(
    .NUM_WAYS (NUM_WAYS)
  ) u_plru (
    .bits_i       (plru_q[idx]),
    .access_way_i (access_way),
    .victim_o     (plru_victim),
    .bits_o       (plru_next)
  );

  // Array and response next-state.
  always_comb begin
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    tag_d            = tag_q;
    data_d           = data_q;
    plru_d           = plru_q;
    rsp_valid_d      = 1'b0;
    rsp_hit_d        = rsp_hit_q;
    rsp_way_d        = rsp_way_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_evict_d      = rsp_evict_q;
    rsp_evict_tag_d  = rsp_evict_tag_q;
    rsp_evict_data_d = rsp_evict_data_q;
    if (req_fire) begin
      rsp_valid_d      = 1'b1;
      rsp_hit_d        = hit;
      rsp_way_d        = hit_way;
      rsp_rdata_d      = '0;
      rsp_evict_d      = 1'b0;
      rsp_evict_tag_d  = '0;
      rsp_evict_data_d = '0;
      case (bus.req_op)
        LOOKUP: begin
          if (hit) begin
            rsp_rdata_d = hit_line;
            plru_d[idx] = plru_next;
          end
        end
        WRITE: begin
          if (hit) begin
            data_d[idx][hit_way]  = merged;
            dirty_d[idx][hit_way] = 1'b1;
            plru_d[idx]           = plru_next;
            rsp_rdata_d           = merged;
          end
        end
        FILL: begin
          rsp_way_d = fill_way;
          if (!hit && valid_q[idx][fill_way] && dirty_q[idx][fill_way]) begin
            rsp_evict_d      = 1'b1;
            rsp_evict_tag_d  = tag_q[idx][fill_way];
            rsp_evict_data_d = data_q[idx][fill_way];
          end
          valid_d[idx][fill_way] = 1'b1;
          dirty_d[idx][fill_way] = bus.req_fill_dirty;
          tag_d[idx][fill_way]   = bus.req_tag;
          data_d[idx][fill_way]  = bus.req_wdata;
          plru_d[idx]            = plru_next;
          rsp_rdata_d            = bus.req_wdata;
        end
        default: ;
      endcase
    end
    // Requests are blocked while flushing, so this never collides with a request update.
    if (wb_clear) begin
      dirty_d[fset_q][fway_q] = 1'b0;
    end
  end

  // Flush engine.
  always_comb begin
    logic advance;
    state_d      = state_q;
    fset_d       = fset_q;
    fway_d       = fway_q;
    wb_valid_d   = wb_valid_q;
    wb_index_d   = wb_index_q;
    wb_tag_d     = wb_tag_q;
    wb_data_d    = wb_data_q;
    flush_done_d = 1'b0;
    wb_clear     = 1'b0;
    advance      = 1'b0;
    case (state_q)
      FlushIdle: begin
        if (flush_start) begin
          state_d = FlushScan;
          fset_d  = '0;
          fway_d  = '0;
        end
      end
      FlushScan: begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          state_d    = FlushWb;
          wb_valid_d = 1'b1;
          wb_index_d = fset_q;
          wb_tag_d   = tag_q[fset_q][fway_q];
          wb_data_d  = data_q[fset_q][fway_q];
        end else begin
          advance = 1'b1;
        end
      end
      FlushWb: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          wb_clear   = 1'b1;
          advance    = 1'b1;
        end
      end
      default: state_d = FlushIdle;
    endcase
    if (advance) begin
      state_d = FlushScan;
      if (fway_q == WAY_W'(NUM_WAYS - 1)) begin
        fway_d = '0;
        if (fset_q == S_INDEX'(SETS - 1)) begin
          state_d      = FlushIdle;
          flush_done_d = 1'b1;
        end else begin
          fset_d = fset_q + 1'b1;
        end
      end else begin
        fway_d = fway_q + 1'b1;
      end
    end
    flush_busy_d = (state_d != FlushIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q          <= '0;
      dirty_q          <= '0;
      tag_q            <= '0;
      data_q           <= '0;
      plru_q           <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_way_q        <= '0;
      rsp_rdata_q      <= '0;
      rsp_evict_q      <= 1'b0;
      rsp_evict_tag_q  <= '0;
      rsp_evict_data_q <= '0;
      state_q          <= FlushIdle;
      fset_q           <= '0;
      fway_q           <= '0;
      wb_valid_q       <= 1'b0;
      wb_index_q       <= '0;
      wb_tag_q         <= '0;
      wb_data_q        <= '0;
      flush_busy_q     <= 1'b0;
      flush_done_q     <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      dirty_q          <= dirty_d;
      tag_q            <= tag_d;
      data_q           <= data_d;
      plru_q           <= plru_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_hit_q        <= rsp_hit_d;
      rsp_way_q        <= rsp_way_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_evict_q      <= rsp_evict_d;
      rsp_evict_tag_q  <= rsp_evict_tag_d;
      rsp_evict_data_q <= rsp_evict_data_d;
      state_q          <= state_d;
      fset_q           <= fset_d;
      fway_q           <= fway_d;
      wb_valid_q       <= wb_valid_d;
      wb_index_q       <= wb_index_d;
      wb_tag_q         <= wb_tag_d;
      wb_data_q        <= wb_data_d;
      flush_busy_q     <= flush_busy_d;
      flush_done_q     <= flush_done_d;
    end
  end

  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_hit        = rsp_hit_q;
  assign bus.rsp_way        = rsp_way_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_evict      = rsp_evict_q;
  assign bus.rsp_evict_tag  = rsp_evict_tag_q;
  assign bus.rsp_evict_data = rsp_evict_data_q;
  assign flush_busy         = flush_busy_q;
  assign flush_done         = flush_done_q;
  assign wb_valid           = wb_valid_q;
  assign wb_index           = wb_index_q;
  assign wb_tag             = wb_tag_q;
  assign wb_data            = wb_data_q;

endmodule

// File: doc/l2_nway_array.md
# l2_nway_array

Parametrised N-way set-associative tag/data store for the L2 cache. It replaces the per-way instances with a single block that adds:
- hit detection across all ways;
- tree-PLRU victim selection with dirty-victim eviction output;
- byte-masked write hits;
- a flush engine that drains every dirty line through a write-back handshake.

It sits between the L2 control FSM and the memory-side write-back path.

## Interface
Parameters:
- S_INDEX, 3: set index width; SETS = 2**S_INDEX.
- NUM_WAYS, 4: associativity; power of two, ≥2.
- TAG_WIDTH, 24: tag width.
- LINE_BYTES, 32: line size; LINE_BITS = 8*LINE_BYTES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  2  l2_op_t: LOOKUP, WRITE, FILL.
- req_index  in  S_INDEX  set.
- req_tag  in  TAG_WIDTH  tag.
- req_wdata  in  LINE_BITS  write/fill data.
- req_wmask  in  LINE_BYTES  byte enables (WRITE only).
- req_fill_dirty  in  1  dirty value for FILL.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  $clog2(NUM_WAYS)  hit way or filled way.
- rsp_rdata  out  LINE_BITS  line contents.
- rsp_evict  out  1  FILL displaced a valid dirty line.
- rsp_evict_tag  out  TAG_WIDTH  tag of the displaced line.
- rsp_evict_data  out  LINE_BITS  data of the displaced line.
- flush_start  in  1  begin flush.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse at flush end.
- wb_valid  out  1  write-back line offered.
- wb_ready  in  1  write-back accepted.
- wb_index  out  S_INDEX  write-back set.
- wb_tag  out  TAG_WIDTH  write-back tag.
- wb_data  out  LINE_BITS  write-back line.

## Operation
- **Storage.** valid, dirty, tag and data per set×way, plus NUM_WAYS-1 PLRU bits per set. All are flops cleared by rst.
- **Hit detection.** Hit = valid && tag match. At most one way matches.
- **LOOKUP.**
  - rsp_hit and rsp_way reflect the match; rsp_rdata is the hit line, or 0 on a miss.
  - A hit updates PLRU.
- **WRITE.**
  - Hit: merge req_wdata bytes where req_wmask=1, set dirty, update PLRU; rsp_rdata is the merged line.
  - Miss: no state change; rsp_hit=0.
- **FILL.**
  - If the tag already hits, overwrite that way; no eviction.
  - Otherwise the victim is the lowest-index invalid way, else the PLRU way.
  - The victim way gets valid=1, dirty=req_fill_dirty, the new tag and the new data. PLRU is updated to that way.
  - rsp_evict=1 only if the old line was valid and dirty; rsp_evict_tag and rsp_evict_data then carry the old contents.
  - rsp_rdata is the new line; rsp_hit reports the pre-fill match.
- **PLRU convention.** Tree PLRU; a node bit of 0 points left (lower ways). An access sets each node on its path to point away from the accessed way.
- **Flush FSM** (IDLE, SCAN, WB):
  - IDLE: flush_start → SCAN at set 0, way 0; flush_busy=1.
  - SCAN: if the entry is valid && dirty → WB; otherwise advance.
  - WB: wb_valid=1 and wb_* held stable until wb_ready. On handshake, clear dirty (valid kept) and advance.
  - Advance: way++, wrapping to way 0 and set++. After the last set/way → IDLE and pulse flush_done.
- **Arbitration.**
  - req_ready = (state==IDLE) && !flush_start; flush_start wins a same-cycle tie.
  - flush_start while busy is ignored.

## Timing
- **Request latency.** A request is accepted at edge N. Arrays update and all rsp_* fields register at edge N; rsp_valid is high for cycle N+1.
- **Back-to-back requests.** A request accepted in cycle N+1 sees the updates made at edge N.
- **No response backpressure.**
- **Output registration.** rsp_*, wb_*, flush_busy and flush_done are registered; only req_ready is combinational.
- **Flush duration.** One cycle per entry in SCAN, plus ≥1 cycle per dirty entry in WB.
- **Reset values.** Every output is 0 in reset except req_ready, which follows the IDLE/flush_start equation. The FSM is in IDLE.
- **Reset mid-flush or mid-request.** rst takes effect immediately: wb_valid and rsp_valid drop and all array state clears.

## Structure
- l2_cache_pkg holds:
  - l2_op_t (LOOKUP=2'b00, WRITE=2'b01, FILL=2'b10);
  - the flush state enum;
  - localparams for LINE_BITS and way-index width.
- One sub-module, l2_plru, is parametrised by NUM_WAYS. It is combinational: PLRU bits in, victim way out, and access way in, next bits out. It is instantiated once and shared across sets by index.

## Test plan
1. **Lookup after reset.** After reset, LOOKUP index 5, tag 0xABCDEF → next cycle rsp_valid=1, rsp_hit=0, rsp_rdata=0.
2. **Fill order and PLRU victim.**
   - FILL index 2 with tags 0x10–0x13 into an empty set → rsp_way 0,1,2,3 in order, rsp_evict=0.
   - Then FILL tag 0x14 → rsp_way=0, rsp_evict=0.
3. **Masked write.**
   - Fill tag 0x11 with all-0x00 data, then WRITE wmask=0x0000000F, wdata all-0xFF → rsp_hit=1.
   - A following LOOKUP returns bytes 0–3 = 0xFF and the rest 0x00.
4. **Dirty eviction.** FILL with req_fill_dirty=1 into all four ways of index 7, then a fifth tag → rsp_evict=1 with the evicted way's tag and data.
5. **Flush with stalls.**
   - Dirty lines exist at index 2 way 1 and index 7 way 3; wb_ready is held low 3 cycles on the first offer.
   - Required: wb_* stable while stalled; write-backs in order (2,1) then (7,3); exactly one flush_done pulse.
   - Afterwards, lookups still hit and a re-flush issues no write-back.
6. **Tie and reset mid-flush.**
   - flush_start and req_valid in the same cycle → req_ready=0 and flush_busy=1 next cycle.
   - rst asserted during WB → wb_valid, flush_busy and all valid bits are 0 immediately.
